// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
//
// Owns the single port of the 2-bit branch-history counter table, which lives
// in an external synchronous-read RAM. After reset it sweeps the whole table to
// INIT_CTR. It buffers branch outcomes committed by the ROB in a small FIFO and
// applies each one as a read-modify-write. It also shares the table port with
// fetch-side prediction lookups.
//
// Port summary
//   clk, rst_n           clock, asynchronous active-low reset
//   rdy                  global run enable; 0 freezes all state and idles the port
//   upd_valid/upd_ready  ROB commit handshake; upd_pc selects the counter,
//                        upd_taken gives the resolved direction
//   lk_req/lk_idx        fetcher lookup request and index
//   lk_grant             lookup issued to the table this cycle
//   lk_rvalid/lk_ctr     lookup result, one cycle after lk_grant
//   tbl_*                table port (en, we, addr, wdata out; rdata in)
//   init_done            clear sweep complete
// -----------------------------------------------------------------------------
module bp_update_scheduler #(
    parameter int         IDX_W      = 12,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_CTR   = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             upd_ready,
    input  logic             lk_req,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_grant,
    output logic             lk_rvalid,
    output logic [1:0]       lk_ctr,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_WR    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_addr;
    logic             r_init_done;
    logic             r_lk_rvalid;

    logic [IDX_W-1:0] r_fifo_idx   [FIFO_DEPTH];
    logic             r_fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t           w_next_state;
    logic             w_tbl_en;
    logic             w_tbl_we;
    logic [IDX_W-1:0] w_tbl_addr;
    logic [1:0]       w_tbl_wdata;
    logic             w_lk_grant;
    logic             w_pop;
    logic             w_push;
    logic             w_upd_ready;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic [1:0]       w_sat_ctr;
    logic             w_unused_pc_bits;

    // Counters are word-indexed by the branch PC; the remaining PC bits do not
    // select a table entry.
    assign w_upd_idx        = upd_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_fifo_empty = (r_count == '0);
    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_head_taken = r_fifo_taken[r_rd_ptr];

    // Ready looks only at the registered count: a pop in the same cycle does
    // not open a slot until the next cycle.
    assign w_upd_ready = rst_n & rdy & ~w_fifo_full;
    assign w_push      = upd_valid & w_upd_ready;

    // Saturating 2-bit counter step; never wraps 3->0 or 0->3.
    always_comb begin
        w_sat_ctr = tbl_rdata;
        if (w_head_taken) begin
            if (tbl_rdata != 2'b11) begin
                w_sat_ctr = tbl_rdata + 2'd1;
            end
        end else begin
            if (tbl_rdata != 2'b00) begin
                w_sat_ctr = tbl_rdata - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and table-port arbitration
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_tbl_en     = 1'b0;
        w_tbl_we     = 1'b0;
        w_tbl_addr   = '0;
        w_tbl_wdata  = 2'b00;
        w_lk_grant   = 1'b0;
        w_pop        = 1'b0;

        if (rdy) begin
            case (r_state)
                ST_CLEAR: begin
                    w_tbl_en    = 1'b1;
                    w_tbl_we    = 1'b1;
                    w_tbl_addr  = r_clr_addr;
                    w_tbl_wdata = INIT_CTR;
                    if (r_clr_addr == LAST_ADDR) begin
                        w_next_state = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // A full FIFO outranks lookups so commits cannot be
                    // starved by a fetcher that requests every cycle.
                    if (w_fifo_full) begin
                        w_tbl_en     = 1'b1;
                        w_tbl_addr   = w_head_idx;
                        w_next_state = ST_WR;
                    end else if (lk_req) begin
                        w_tbl_en   = 1'b1;
                        w_tbl_addr = lk_idx;
                        w_lk_grant = 1'b1;
                    end else if (!w_fifo_empty) begin
                        w_tbl_en     = 1'b1;
                        w_tbl_addr   = w_head_idx;
                        w_next_state = ST_WR;
                    end
                end

                ST_WR: begin
                    // tbl_rdata still holds the read issued in the previous
                    // port cycle, even across a pause, because the RAM keeps
                    // its output while tbl_en is low.
                    w_tbl_en     = 1'b1;
                    w_tbl_we     = 1'b1;
                    w_tbl_addr   = w_head_idx;
                    w_tbl_wdata  = w_sat_ctr;
                    w_pop        = 1'b1;
                    w_next_state = ST_RUN;
                end

                default: begin
                    w_next_state = ST_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
            r_lk_rvalid <= 1'b0;
        end else if (rdy) begin
            r_state     <= w_next_state;
            r_lk_rvalid <= w_lk_grant;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Update FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy count alone decides which
    // entries are meaningful, and leaving the array unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]   <= w_upd_idx;
            r_fifo_taken[r_wr_ptr] <= upd_taken;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; forced low asynchronously while reset is asserted so an
    // in-flight write is dropped at once.
    // ------------------------------------------------------------------
    assign upd_ready = w_upd_ready;
    assign lk_grant  = w_lk_grant & rst_n;
    assign lk_rvalid = r_lk_rvalid;
    assign lk_ctr    = r_lk_rvalid ? tbl_rdata : 2'b00;
    assign tbl_en    = w_tbl_en & rst_n;
    assign tbl_we    = w_tbl_we & rst_n;
    assign tbl_addr  = w_tbl_addr & {IDX_W{rst_n}};
    assign tbl_wdata = w_tbl_wdata & {2{rst_n}};
    assign init_done = r_init_done;

endmodule
